// File: rtl/sum_arbiter.sv
// Round-robin, ownership-locking arbiter sharing one WIDTH-bit adder among NUM_REQ iterative requesters.
// Optional macro ARB_STATS_EN adds per-requester saturating grant-cycle counters on stat_cycles.
module sum_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] op_a,
    input  logic [NUM_REQ*WIDTH-1:0] op_b,
    output logic [NUM_REQ-1:0]       grant,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                     busy,
    output logic [WIDTH-1:0]         sum_in_a,
    output logic [WIDTH-1:0]         sum_in_b,
    input  logic [WIDTH-1:0]         sum_out,
    output logic [WIDTH-1:0]         result
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]    stat_cycles
`endif
);

    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [IDW-1:0]       rr_q, rr_d;
    logic                 busy_q, busy_d;
    logic [IDW-1:0]       nxt_ptr;
    logic [IDW:0]         pick;
    logic [WIDTH-1:0]     sel_a, sel_b;

    // First requester at or after base (wrapping); MSB flags that one was found.
    function automatic logic [IDW:0] find_winner(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDW-1:0]     base);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            idx = int'(base) + k;
            if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
            if (r[IDW'(idx)]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    assign nxt_ptr = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            rr_q       <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            rr_q       <= rr_d;
            busy_q     <= busy_d;
        end
    end

    // Grant on request from idle; hold while owner requests; hand off on the release edge.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        rr_d       = rr_q;
        busy_d     = busy_q;
        pick       = '0;
        case (state_q)
            IDLE: begin
                pick = find_winner(req, rr_q);
                if (pick[IDW]) begin
                    state_d    = OWNED;
                    grant_d    = NUM_REQ'(1) << pick[IDW-1:0];
                    grant_id_d = pick[IDW-1:0];
                    busy_d     = 1'b1;
                end
            end
            OWNED: begin
                if (!req[grant_id_q]) begin
                    rr_d = nxt_ptr;
                    pick = find_winner(req, nxt_ptr);
                    if (pick[IDW]) begin
                        grant_d    = NUM_REQ'(1) << pick[IDW-1:0];
                        grant_id_d = pick[IDW-1:0];
                    end else begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        grant_id_d = '0;
                        busy_d     = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // AND-OR operand select so unowned slices (even X) never reach the adder.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (busy_q && grant_q[i]) begin
                sel_a = sel_a | op_a[i*WIDTH +: WIDTH];
                sel_b = sel_b | op_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign sum_in_a = sel_a;
    assign sum_in_b = sel_b;
    assign result   = sum_out;

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_cycles <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (grant_q[i] && (stat_cycles[i*16 +: 16] != 16'hFFFF))
                    stat_cycles[i*16 +: 16] <= stat_cycles[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sum_arbiter.sv
// Self-checking bench for sum_arbiter (NUM_REQ=2, WIDTH=16) with a behavioural adder as the shared sum unit.
module tb_sum_arbiter;

    logic        clk;
    logic        rst;
    logic        req_drv [2];
    logic [15:0] a_drv   [2];
    logic [15:0] b_drv   [2];
    logic [1:0]  req;
    logic [31:0] op_a, op_b;
    logic [1:0]  grant;
    logic        grant_id;
    logic        busy;
    logic [15:0] sum_in_a, sum_in_b, sum_out, result;
`ifdef ARB_STATS_EN
    logic [31:0] stat_cycles;
`endif

    int n_vec = 0;
    int n_err = 0;

    assign req     = {req_drv[1], req_drv[0]};
    assign op_a    = {a_drv[1], a_drv[0]};
    assign op_b    = {b_drv[1], b_drv[0]};
    assign sum_out = sum_in_a + sum_in_b;

    sum_arbiter #(.NUM_REQ(2), .WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .op_a     (op_a),
        .op_b     (op_b),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .sum_in_a (sum_in_a),
        .sum_in_b (sum_in_b),
        .sum_out  (sum_out),
        .result   (result)
`ifdef ARB_STATS_EN
        ,
        .stat_cycles (stat_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [15:0] a0, b0, a1, b1;
        logic [1:0]  grant;
        logic        id;
        logic        busy;
        logic [15:0] sa, sb, res;
    } vec_t;

    vec_t        vecs [11];
    vec_t        sb_q [$];
    logic [15:0] mul_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] r);
        req_drv[0] = r[0];
        req_drv[1] = r[1];
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_req(2'b00);
        for (int i = 0; i < 2; i++) begin
            a_drv[i] = '0;
            b_drv[i] = '0;
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Shift-add multiplier that borrows the shared adder for 8 granted cycles.
    task automatic run_mul(input int i, input logic [7:0] a, input logic [7:0] b,
                           output logic [15:0] prod);
        int          n;
        logic [15:0] acc;
        acc = '0;
        n   = 0;
        req_drv[i] = 1'b1;
        tick();
        while (!grant[i] && n < 50) begin
            tick();
            n++;
        end
        check($sformatf("mul%0d_grant_wait", i), 32'(grant[i]), 32'd1);
        for (int bit_i = 0; bit_i < 8; bit_i++) begin
            a_drv[i] = acc;
            b_drv[i] = b[bit_i] ? (16'(a) << bit_i) : 16'd0;
            @(negedge clk);
            acc = result;
            tick();
        end
        req_drv[i] = 1'b0;
        a_drv[i]   = '0;
        b_drv[i]   = '0;
        prod = acc;
    endtask

    initial begin
        logic [1:0]  exp_g;
        logic [15:0] p0, p1, e0, e1;
        vec_t        v, e;

        vecs[0]  = '{2'b01, 16'd3,   16'd2,   16'd0,      16'd0, 2'b01, 1'b0, 1'b1, 16'd3,      16'd2,   16'd5};
        vecs[1]  = '{2'b01, 16'd100, 16'd200, 16'd0,      16'd0, 2'b01, 1'b0, 1'b1, 16'd100,    16'd200, 16'd300};
        vecs[2]  = '{2'b00, 16'd100, 16'd200, 16'd0,      16'd0, 2'b00, 1'b0, 1'b0, 16'd0,      16'd0,   16'd0};
        vecs[3]  = '{2'b11, 16'd1,   16'd1,   16'd7,      16'd8, 2'b10, 1'b1, 1'b1, 16'd7,      16'd8,   16'd15};
        vecs[4]  = '{2'b11, 16'd1,   16'd1,   16'hFFFF,   16'd2, 2'b10, 1'b1, 1'b1, 16'hFFFF,   16'd2,   16'd1};
        vecs[5]  = '{2'b01, 16'd1,   16'd1,   16'hFFFF,   16'd2, 2'b01, 1'b0, 1'b1, 16'd1,      16'd1,   16'd2};
        vecs[6]  = '{2'b11, 16'd1,   16'd1,   16'hFFFF,   16'd2, 2'b01, 1'b0, 1'b1, 16'd1,      16'd1,   16'd2};
        vecs[7]  = '{2'b10, 16'd1,   16'd1,   16'hFFFF,   16'd2, 2'b10, 1'b1, 1'b1, 16'hFFFF,   16'd2,   16'd1};
        vecs[8]  = '{2'b00, 16'd1,   16'd1,   16'hFFFF,   16'd2, 2'b00, 1'b0, 1'b0, 16'd0,      16'd0,   16'd0};
        vecs[9]  = '{2'b10, 16'd1,   16'd1,   16'hFFFF,   16'd2, 2'b10, 1'b1, 1'b1, 16'hFFFF,   16'd2,   16'd1};
        vecs[10] = '{2'b00, 16'd1,   16'd1,   16'hFFFF,   16'd2, 2'b00, 1'b0, 1'b0, 16'd0,      16'd0,   16'd0};

        rst = 1'b0;
        set_req(2'b11);
        a_drv[0] = 16'd5; b_drv[0] = 16'd6;
        a_drv[1] = 16'd7; b_drv[1] = 16'd8;
        #2;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum_a", 32'(sum_in_a), 32'd0);
        check("rst_sum_b", 32'(sum_in_b), 32'd0);
        do_reset();

        // Table-driven sequence through the scoreboard.
        for (int k = 0; k < 11; k++) begin
            v = vecs[k];
            set_req(v.req);
            a_drv[0] = v.a0; b_drv[0] = v.b0;
            a_drv[1] = v.a1; b_drv[1] = v.b1;
            sb_q.push_back(v);
            tick();
            e = sb_q.pop_front();
            check($sformatf("v%0d_grant", k), 32'(grant), 32'(e.grant));
            check($sformatf("v%0d_id", k), 32'(grant_id), 32'(e.id));
            check($sformatf("v%0d_busy", k), 32'(busy), 32'(e.busy));
            check($sformatf("v%0d_sum_a", k), 32'(sum_in_a), 32'(e.sa));
            check($sformatf("v%0d_sum_b", k), 32'(sum_in_b), 32'(e.sb));
            check($sformatf("v%0d_result", k), 32'(result), 32'(e.res));
        end

        // Contention with a long lock, then same-edge handoff.
        do_reset();
        set_req(2'b11);
        a_drv[0] = 16'd9; b_drv[0] = 16'd9;
        a_drv[1] = 16'd4; b_drv[1] = 16'd4;
        tick();
        check("cont_first", 32'(grant), 32'b01);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("cont_hold%0d", k), 32'(grant), 32'b01);
        end
        set_req(2'b10);
        tick();
        check("cont_handoff", 32'(grant), 32'b10);
        check("cont_handoff_busy", 32'(busy), 32'd1);
        check("cont_handoff_res", 32'(result), 32'd8);

        // Async reset while owned, then arbitration restarts from requester 0.
        set_req(2'b11);
        rst = 1'b0;
        #1;
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sum_a", 32'(sum_in_a), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("postrst_grant", 32'(grant), 32'b01);

        // Fairness: each owner completes, drops for a cycle, re-requests.
        do_reset();
        set_req(2'b11);
        tick();
        exp_g = 2'b01;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fair%0d", k), 32'(grant), 32'(exp_g));
            set_req(~grant);
            tick();
            set_req(2'b11);
            tick();
            exp_g = ~exp_g;
        end

        // Two shift-add multipliers started in the same cycle.
        do_reset();
        e0 = 16'd65025;
        e1 = 16'd25;
        mul_q.push_back(e0);
        mul_q.push_back(e1);
        fork
            run_mul(0, 8'd255, 8'd255, p0);
            run_mul(1, 8'd5,   8'd5,   p1);
        join
        check("mul0_result", 32'(p0), 32'(mul_q.pop_front()));
        check("mul1_result", 32'(p1), 32'(mul_q.pop_front()));
        tick();
        check("mul_busy_drop", 32'(busy), 32'd0);
        check("mul_grant_drop", 32'(grant), 32'd0);

`ifdef ARB_STATS_EN
        do_reset();
        set_req(2'b10);
        tick();
        for (int k = 0; k < 6; k++) tick();
        set_req(2'b00);
        tick();
        check("stat_req1", 32'(stat_cycles[31:16]), 32'd7);
        check("stat_req0", 32'(stat_cycles[15:0]), 32'd0);
        rst = 1'b0;
        #1;
        check("stat_rst", stat_cycles, 32'd0);
        tick();
        rst = 1'b1;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
